// File: rtl/datapath_sequencer.sv
// Instruction sequencer driving a register-file/ALU datapath.
// Decodes 16-bit instructions into registered datapath control.
module datapath_sequencer #(
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr_i,
  input  logic        instr_valid_i,
  output logic        instr_ready_o,
  input  logic        Flag,
  output logic [3:0]  Sel,
  output logic        Wen,
  output logic [3:0]  WA,
  output logic [3:0]  RAA,
  output logic [3:0]  RAB,
  output logic [2:0]  Op,
  output logic [7:0]  Ctrl,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WB,
    HALT
  } state_t;

  state_t     state;
  logic [3:0] opc;
  logic [3:0] wa_r;
  logic       skip_pending;
  logic       wen_q;
  logic       done_q;
  logic       err_q;
  logic       accept;

  logic i_alu, i_load, i_out, i_skip, i_ctrl, i_nop;
  logic x_alu, x_load, x_skip, x_ill;

  assign instr_ready_o = (state == IDLE);
  assign busy_o        = (state != IDLE);
  assign accept        = instr_valid_i & instr_ready_o;

  assign i_alu  = ~instr_i[15];
  assign i_load = (instr_i[15:12] == 4'h8);
  assign i_out  = (instr_i[15:12] == 4'h9);
  assign i_skip = (instr_i[15:12] == 4'hA);
  assign i_ctrl = (instr_i[15:12] == 4'hB);
  assign i_nop  = (instr_i[15:12] == 4'hF);

  assign x_alu  = ~opc[3];
  assign x_load = (opc == 4'h8);
  assign x_skip = (opc == 4'hA);
  assign x_ill  = (opc[3:2] == 2'b11) && (opc != 4'hF);

  // Reset kills a WB write or retire pulse in the same cycle
  assign Wen    = wen_q & ~rst;
  assign done_o = done_q & ~rst;
  assign err_o  = err_q & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      opc          <= 4'h0;
      wa_r         <= 4'h0;
      skip_pending <= 1'b0;
      Ctrl         <= 8'h00;
      wen_q        <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      Sel          <= 4'h0;
      Op           <= 3'h0;
      WA           <= 4'h0;
      RAA          <= 4'h0;
      RAB          <= 4'h0;
    end else begin
      wen_q  <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state)
        IDLE: begin
          Sel <= 4'h0;
          Op  <= 3'h0;
          WA  <= 4'h0;
          RAA <= 4'h0;
          RAB <= 4'h0;
          if (accept && skip_pending) begin
            skip_pending <= 1'b0;
          end else if (accept) begin
            opc   <= instr_i[15:12];
            wa_r  <= instr_i[11:8];
            state <= EXEC;
            unique case (1'b1)
              i_alu: begin
                Op  <= instr_i[14:12];
                RAA <= instr_i[7:4];
                RAB <= instr_i[3:0];
              end
              i_load: begin
                Sel <= {1'b1, instr_i[2:0]};
              end
              i_out: begin
                Op     <= 3'b100;
                RAA    <= instr_i[7:4];
                done_q <= 1'b1;
              end
              i_ctrl: begin
                Ctrl   <= instr_i[7:0];
                done_q <= 1'b1;
              end
              i_skip, i_nop: begin
                done_q <= 1'b1;
              end
              default: begin
                err_q <= 1'b1;
              end
            endcase
          end
        end
        EXEC: begin
          if (x_alu || x_load) begin
            state  <= WB;
            wen_q  <= 1'b1;
            WA     <= wa_r;
            done_q <= 1'b1;
          end else begin
            state <= (x_ill && HALT_ON_ILLEGAL) ? HALT : IDLE;
            Sel   <= 4'h0;
            Op    <= 3'h0;
            WA    <= 4'h0;
            RAA   <= 4'h0;
            RAB   <= 4'h0;
            if (x_skip && Flag) begin
              skip_pending <= 1'b1;
            end
          end
        end
        WB: begin
          state <= IDLE;
          Sel   <= 4'h0;
          Op    <= 3'h0;
          WA    <= 4'h0;
          RAA   <= 4'h0;
          RAB   <= 4'h0;
        end
        HALT: begin
          Sel <= 4'h0;
          Op  <= 3'h0;
          WA  <= 4'h0;
          RAA <= 4'h0;
          RAB <= 4'h0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Scoreboard bench for datapath_sequencer.
// Second instance covers halt-on-illegal behaviour.
module tb_datapath_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr;
  logic        valid;
  logic        flag;

  logic        ready, wen, busy, done, err;
  logic [3:0]  sel, wa, raa, rab;
  logic [2:0]  op;
  logic [7:0]  ctrl;

  logic        h_ready, h_wen, h_busy, h_done, h_err;
  logic [3:0]  h_sel, h_wa, h_raa, h_rab;
  logic [2:0]  h_op;
  logic [7:0]  h_ctrl;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          kind;
    logic [10:0] data;
  } ev_t;

  ev_t sbq[$];

  always #5 clk = ~clk;

  datapath_sequencer dut (
    .clk(clk), .rst(rst),
    .instr_i(instr), .instr_valid_i(valid),
    .instr_ready_o(ready), .Flag(flag),
    .Sel(sel), .Wen(wen), .WA(wa),
    .RAA(raa), .RAB(rab), .Op(op),
    .Ctrl(ctrl), .busy_o(busy),
    .done_o(done), .err_o(err)
  );

  datapath_sequencer #(.HALT_ON_ILLEGAL(1'b1)) dut_h (
    .clk(clk), .rst(rst),
    .instr_i(instr), .instr_valid_i(valid),
    .instr_ready_o(h_ready), .Flag(flag),
    .Sel(h_sel), .Wen(h_wen), .WA(h_wa),
    .RAA(h_raa), .RAB(h_rab), .Op(h_op),
    .Ctrl(h_ctrl), .busy_o(h_busy),
    .done_o(h_done), .err_o(h_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int kind, input logic [10:0] d);
    ev_t e;
    e.kind = kind;
    e.data = d;
    sbq.push_back(e);
  endtask

  task automatic pop(input int kind, input logic [10:0] d);
    ev_t e;
    if (sbq.size() == 0) begin
      chk("sb_unexpected", sbq.size(), 1);
    end else begin
      e = sbq.pop_front();
      chk("sb_kind", kind, e.kind);
      chk("sb_data", d, e.data);
    end
  endtask

  // kind 0 = write, 1 = retire, 2 = illegal
  always @(negedge clk) begin
    if (!rst) begin
      if (wen)  pop(0, {wa, sel, op});
      if (done) pop(1, 11'h0);
      if (err)  pop(2, 11'h0);
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Returns #1 after the accepting edge, i.e. in cycle N+1
  task automatic issue(input logic [15:0] ins);
    int n;
    n = 0;
    instr = ins;
    valid = 1'b1;
    @(negedge clk);
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ready) chk("issue_timeout", ready, 1);
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    valid = 1'b0;
    instr = 16'h0;
    flag  = 1'b0;
    step();
    step();
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_wen", wen, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_ctrl", ctrl, 8'h00);
    chk("rst_ctl", {sel, op, wa, raa, rab}, 0);
    rst = 1'b0;
    step();

    // ADD r3 = r1 op r2
    push(0, {4'h3, 4'h0, 3'h0});
    push(1, 11'h0);
    issue(16'h0312);
    chk("add_n1_op", op, 3'h0);
    chk("add_n1_raa", raa, 4'h1);
    chk("add_n1_rab", rab, 4'h2);
    chk("add_n1_wen", wen, 0);
    chk("add_n1_rdy", ready, 0);
    chk("add_n1_busy", busy, 1);
    step();
    chk("add_n2_wen", wen, 1);
    chk("add_n2_wa", wa, 4'h3);
    chk("add_n2_done", done, 1);
    step();
    chk("add_n3_rdy", ready, 1);
    chk("add_n3_wen", wen, 0);

    push(0, {4'hA, 4'h0, 3'h5});
    push(1, 11'h0);
    issue(16'h5AB4);
    chk("alu5_op", op, 3'h5);
    chk("alu5_raa", raa, 4'hB);
    chk("alu5_rab", rab, 4'h4);
    step();
    step();

    // LOAD from InPort byte 6
    push(0, {4'h7, 4'hE, 3'h0});
    push(1, 11'h0);
    issue(16'h8706);
    chk("ld_n1_sel", sel, 4'hE);
    chk("ld_n1_wen", wen, 0);
    step();
    chk("ld_n2_sel", sel, 4'hE);
    chk("ld_n2_wa", wa, 4'h7);
    chk("ld_n2_wen", wen, 1);
    step();

    push(1, 11'h0);
    issue(16'hB0A5);
    chk("ctrl_n1", ctrl, 8'hA5);
    chk("ctrl_done", done, 1);
    step();
    chk("ctrl_n2_rdy", ready, 1);
    push(0, {4'h3, 4'h0, 3'h0});
    push(1, 11'h0);
    issue(16'h0312);
    step();
    step();
    chk("ctrl_held", ctrl, 8'hA5);

    // SKIPZ taken: next instruction discarded
    flag = 1'b1;
    push(1, 11'h0);
    issue(16'hA000);
    chk("skz_done", done, 1);
    step();
    flag = 1'b0;
    issue(16'h0312);
    chk("skip_busy", busy, 0);
    chk("skip_rdy", ready, 1);
    chk("skip_done", done, 0);
    push(1, 11'h0);
    issue(16'h9050);
    chk("out_op", op, 3'h4);
    chk("out_raa", raa, 4'h5);
    chk("out_wen", wen, 0);
    step();
    chk("out_n2_rdy", ready, 1);

    // SKIPZ not taken: next instruction executes
    push(1, 11'h0);
    issue(16'hA000);
    step();
    push(0, {4'h3, 4'h0, 3'h0});
    push(1, 11'h0);
    issue(16'h0312);
    chk("noskip_busy", busy, 1);
    step();
    chk("noskip_wen", wen, 1);
    step();

    push(1, 11'h0);
    issue(16'hF000);
    chk("nop_wen", wen, 0);
    chk("nop_ctl", {sel, op}, 0);
    step();

    // Illegal: drop here, halt in the second instance
    push(2, 11'h0);
    issue(16'hC000);
    chk("ill_err", err, 1);
    chk("ill_done", done, 0);
    chk("ill_h_err", h_err, 1);
    step();
    chk("ill_n2_rdy", ready, 1);
    chk("ill_n2_err", err, 0);
    chk("halt_rdy", h_ready, 0);
    chk("halt_busy", h_busy, 1);
    step();
    step();
    chk("halt_rdy2", h_ready, 0);
    chk("halt_ctl", {h_wen, h_sel, h_op, h_wa}, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("halt_rst_rdy", h_ready, 1);
    chk("halt_rst_busy", h_busy, 0);
    step();

    // Reset during WB aborts the write
    push(1, 11'h0);
    issue(16'hB0A5);
    step();
    issue(16'h0312);
    step();
    rst = 1'b1;
    #1;
    chk("wbrst_wen", wen, 0);
    chk("wbrst_done", done, 0);
    step();
    chk("wbrst_wen2", wen, 0);
    chk("wbrst_ctrl", ctrl, 8'h00);
    rst = 1'b0;
    step();
    chk("wbrst_rdy", ready, 1);
    chk("wbrst_done2", done, 0);

    // Reset wins over a same-cycle accept
    instr = 16'h0312;
    valid = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    valid = 1'b0;
    chk("rstpri_busy", busy, 0);
    step();
    chk("rstpri_busy2", busy, 0);
    step();
    step();
    chk("sb_drain", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
